// File: rtl/wb_trace_display.sv
// Write-back trace: circular history of register write-backs scanned oldest->newest onto LEDs (optional WB_TRACE_FREEZE_EN adds freeze).
// Latency: count/ovf update on the sampling edge; led is registered, one cycle behind rd_idx/disp_sel/memory.
// Backpressure: none; wr_en may be asserted every cycle, a full trace overwrites its oldest entry.
module wb_trace_display #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int LED_W  = 8,
    parameter int DIV    = 100000000,
    localparam int AW    = $clog2(DEPTH),
    localparam int NS    = DATA_W / LED_W,
    localparam int SW    = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic [SW-1:0]     disp_sel,
`ifdef WB_TRACE_FREEZE_EN
    input  logic              freeze,
`endif
    output logic [LED_W-1:0]  led,
    output logic [AW:0]       count,
    output logic [AW-1:0]     rd_idx,
    output logic              ovf
);

    localparam int DW = $clog2(DIV);

`ifdef WB_TRACE_FREEZE_EN
    typedef enum logic [1:0] {EMPTY, SCAN, FROZEN} state_t;
`else
    typedef enum logic [1:0] {EMPTY, SCAN} state_t;
`endif

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     div_cnt;
    logic [DATA_W-1:0] rd_word;
    logic [LED_W-1:0]  slice;
    logic              cap;
    logic              full;
    logic              step;

`ifdef WB_TRACE_FREEZE_EN
    assign cap = wr_en & ~freeze;
`else
    assign cap = wr_en;
`endif

    assign full    = (count == (AW+1)'(DEPTH));
    assign step    = (div_cnt == DW'(DIV - 1));
    // rd_idx is relative to the oldest entry; a full trace truncates count to 0, landing on wr_ptr
    assign rd_addr = wr_ptr - count[AW-1:0] + rd_idx;
    assign rd_word = mem[rd_addr];

    always_comb begin
        slice = '0;
        for (int i = 0; i < NS; i++) begin
            if (disp_sel == SW'(i)) begin
                slice = rd_word[i*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            rd_idx  <= '0;
            div_cnt <= '0;
            led     <= '0;
        end else if (clr) begin
            state   <= EMPTY;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            rd_idx  <= '0;
            div_cnt <= '0;
            led     <= '0;
        end else begin
            if (cap) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + (AW+1)'(1);
                end
            end

            case (state)
                EMPTY: begin
                    led     <= '0;
                    rd_idx  <= '0;
                    div_cnt <= '0;
                    if (cap) begin
                        state <= SCAN;
                    end
                end
                default: begin
                    led <= slice;
                    if (step) begin
                        div_cnt <= '0;
                        rd_idx  <= ({1'b0, rd_idx} == count - (AW+1)'(1)) ? '0 : rd_idx + AW'(1);
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
`ifdef WB_TRACE_FREEZE_EN
                    if (freeze) begin
                        state <= FROZEN;
                    end else if (count == '0) begin
                        state <= EMPTY;
                    end else begin
                        state <= SCAN;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_display.sv
// Bench for wb_trace_display: directed scenarios plus randomized traffic against a queue-based trace model.
module tb_wb_trace_display;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int LED_W  = 8;
    localparam int DIV    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        clr = 1'b0;
    logic [1:0]  disp_sel = '0;
    logic [7:0]  led;
    logic [3:0]  count;
    logic [2:0]  rd_idx;
    logic        ovf;
    logic        frz;

    int checks = 0;
    int errors = 0;

`ifdef WB_TRACE_FREEZE_EN
    logic freeze = 1'b0;
    assign frz = freeze;
`else
    assign frz = 1'b0;
`endif

    wb_trace_display #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LED_W(LED_W), .DIV(DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr      (clr),
        .disp_sel (disp_sel),
`ifdef WB_TRACE_FREEZE_EN
        .freeze   (freeze),
`endif
        .led      (led),
        .count    (count),
        .rd_idx   (rd_idx),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: history as a queue (oldest at front), scan position and cycles since last step.
    logic [31:0] hist[$];
    bit          m_ovf   = 1'b0;
    int          m_rd    = 0;
    int          m_phase = 0;
    bit          m_scan  = 1'b0;
    logic [7:0]  m_led   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_ovf = 1'b0; m_rd = 0; m_phase = 0; m_scan = 1'b0; m_led = '0;
        end else begin
            logic [7:0]  nled;
            logic [31:0] word;
            int          n;
            n    = hist.size();
            nled = '0;
            if (m_scan) begin
                word = hist[m_rd];
                nled = word[disp_sel*8 +: 8];
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_rd    = (m_rd + 1) % n;
                end
            end
            m_led = nled;
            if (clr) begin
                hist.delete();
                m_ovf = 1'b0; m_rd = 0; m_phase = 0; m_scan = 1'b0; m_led = '0;
            end else if (wr_en && !frz) begin
                hist.push_back(wr_data);
                if (hist.size() > DEPTH) begin
                    void'(hist.pop_front());
                    m_ovf = 1'b1;
                end
                if (!m_scan) begin
                    m_scan  = 1'b1;
                    m_phase = 0;
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] d, input logic c);
        wr_en = we; wr_data = d; clr = c;
        @(negedge clk);
        wr_en = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
            checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
            checks++; if (rd_idx !== 3'd0) begin errors++; $display("FAIL reset_rd_idx: got %0d expected 0", rd_idx); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_basic_scan();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        drive(1'b1, 32'h11, 1'b0);
        drive(1'b1, 32'h22, 1'b0);
        drive(1'b1, 32'h33, 1'b0);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
        // k counts edges since the first write; led trails rd_idx by one edge
        for (int k = 3; k <= 14; k++) begin
            drive(1'b0, 32'h0, 1'b0);
            checks++;
            if (led !== vals[((k - 1) / DIV) % 3]) begin
                errors++; $display("FAIL basic_led k=%0d: got %h expected %h", k, led, vals[((k - 1) / DIV) % 3]);
            end
            checks++;
            if (rd_idx !== 3'((k / DIV) % 3)) begin
                errors++; $display("FAIL basic_rd_idx k=%0d: got %0d expected %0d", k, rd_idx, (k / DIV) % 3);
            end
        end
    endtask

    task automatic test_overflow();
        logic [2:0] prev_rd;
        drive(1'b0, 32'h0, 1'b1);
        for (int v = 1; v <= 10; v++) drive(1'b1, 32'(v), 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        prev_rd = rd_idx;
        for (int k = 0; k < 36; k++) begin
            drive(1'b0, 32'h0, 1'b0);
            checks++;
            if (led !== 8'(3 + prev_rd)) begin
                errors++; $display("FAIL ovf_order k=%0d: got %h expected %h", k, led, 8'(3 + prev_rd));
            end
            prev_rd = rd_idx;
        end
    endtask

    task automatic test_clear_collision();
        drive(1'b1, 32'h55, 1'b1);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL clr_full_count: got %0d expected 0", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_full_ovf: got %b expected 0", ovf); end
        for (int v = 0; v < 5; v++) drive(1'b1, 32'hC0 + 32'(v), 1'b0);
        repeat (3) drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h55, 1'b1);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL clr_led: got %h expected 00", led); end
        checks++; if (rd_idx !== 3'd0) begin errors++; $display("FAIL clr_rd_idx: got %0d expected 0", rd_idx); end
        drive(1'b1, 32'h66, 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL clr_drop_count: got %0d expected 1", count); end
        checks++; if (led !== 8'h66) begin errors++; $display("FAIL clr_drop_led: got %h expected 66", led); end
    endtask

    task automatic test_slice();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'hAABBCCDD, 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b0);
        for (int s = 3; s >= 0; s--) begin
            disp_sel = 2'(s);
            @(negedge clk);
            checks++;
            if (led !== exp_b[s]) begin
                errors++; $display("FAIL slice sel=%0d: got %h expected %h", s, led, exp_b[s]);
            end
        end
        disp_sel = 2'd2;
        @(negedge clk);
        checks++; if (led !== 8'hBB) begin errors++; $display("FAIL slice_hold: got %h expected bb", led); end
        disp_sel = 2'd0;
    endtask

    task automatic test_async_reset();
        drive(1'b0, 32'h0, 1'b1);
        for (int v = 1; v <= 3; v++) drive(1'b1, 32'(v), 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL arst_led: got %h expected 00", led); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
        checks++; if (rd_idx !== 3'd0) begin errors++; $display("FAIL arst_rd_idx: got %0d expected 0", rd_idx); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h7F, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 32'h0, 1'b0);
            checks++; if (led !== 8'h7F) begin errors++; $display("FAIL arst_led_after k=%0d: got %h expected 7f", k, led); end
            checks++; if (rd_idx !== 3'd0) begin errors++; $display("FAIL arst_rd_after k=%0d: got %0d expected 0", k, rd_idx); end
        end
    endtask

`ifdef WB_TRACE_FREEZE_EN
    task automatic test_freeze();
        logic [3:0] cnt0;
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'hA1, 1'b0);
        drive(1'b1, 32'hA2, 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b0);
        cnt0   = count;
        freeze = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(k < 3, 32'hF0 + 32'(k), 1'b0);
            checks++; if (count !== cnt0) begin errors++; $display("FAIL frz_count k=%0d: got %0d expected %0d", k, count, cnt0); end
            checks++; if (rd_idx !== 3'(m_rd)) begin errors++; $display("FAIL frz_rd_idx k=%0d: got %0d expected %0d", k, rd_idx, m_rd); end
            checks++; if (led !== m_led) begin errors++; $display("FAIL frz_led k=%0d: got %h expected %h", k, led, m_led); end
        end
        freeze = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'hB7, 1'b0);
        checks++; if (count !== cnt0 + 4'd1) begin errors++; $display("FAIL frz_resume: got %0d expected %0d", count, cnt0 + 4'd1); end
    endtask
`endif

    task automatic test_random();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            wr_en    = ($urandom_range(0, 4) == 0);
            wr_data  = $urandom;
            clr      = ($urandom_range(0, 79) == 0);
            disp_sel = 2'($urandom_range(0, 3));
`ifdef WB_TRACE_FREEZE_EN
            freeze   = ($urandom_range(0, 9) == 0);
`endif
            @(negedge clk);
            checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led i=%0d: got %h expected %h", i, led, m_led); end
            checks++; if (count !== 4'(hist.size())) begin errors++; $display("FAIL rand_count i=%0d: got %0d expected %0d", i, count, hist.size()); end
            checks++; if (rd_idx !== 3'(m_rd)) begin errors++; $display("FAIL rand_rd_idx i=%0d: got %0d expected %0d", i, rd_idx, m_rd); end
            checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf i=%0d: got %b expected %b", i, ovf, m_ovf); end
        end
        wr_en = 1'b0; clr = 1'b0; disp_sel = '0;
`ifdef WB_TRACE_FREEZE_EN
        freeze = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_overflow();
        test_clear_collision();
        test_slice();
        test_async_reset();
`ifdef WB_TRACE_FREEZE_EN
        test_freeze();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
